// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing over req/ack memories,
// with run/halt, memory timeouts, an error state and cycle/instret counters.
module multicycle_ctrl #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            err_clr,
  input  logic [6:0]      opcode,
  input  logic            zero,
  output logic            imem_req,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            ir_write,
  output logic            pc_write,
  output logic            pc_src,
  output logic            alu_src_b,
  output logic [1:0]      aluop,
  output logic            reg_write,
  output logic            mem2reg,
  output logic [2:0]      state,
  output logic [1:0]      err_code,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH
  } cls_e;

  localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d;
  logic [1:0]        err_q, err_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [XLEN-1:0]   cyc_q, cyc_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic              retire;
  logic              dec_legal;
  cls_e              dec_cls;

  always_comb begin
    dec_legal = 1'b1;
    dec_cls   = C_R;
    case (opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      default:    dec_legal = 1'b0;
    endcase
  end

  // Timeout counter defaults to zero so it is cleared on every entry to FETCH/MEM.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    err_d   = err_q;
    tmo_d   = '0;
    cyc_d   = cyc_q;
    inst_d  = inst_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
          err_d   = 2'd1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          cls_d   = dec_cls;
          state_d = S_EXEC;
        end else begin
          state_d = S_ERR;
          err_d   = 2'd2;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_BRANCH:    retire  = 1'b1;
          C_R, C_I:    state_d = S_WB;
          default:     state_d = S_MEM;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (cls_q == C_STORE) retire = 1'b1;
          else                  state_d = S_WB;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
          err_d   = 2'd3;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_WB: retire = 1'b1;
      S_ERR: begin
        if (err_clr) begin
          state_d = S_IDLE;
          err_d   = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (retire) begin
      inst_d  = inst_q + 1'b1;
      state_d = run ? S_FETCH : S_IDLE;
    end
    if (state_q != S_IDLE && state_q != S_ERR) cyc_d = cyc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cls_q   <= C_R;
      err_q   <= '0;
      tmo_q   <= '0;
      cyc_q   <= '0;
      inst_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      cyc_q   <= cyc_d;
      inst_q  <= inst_d;
    end
  end

  // Fetch strobes follow imem_ack combinationally so a zero-wait fetch takes one cycle.
  always_comb begin
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    alu_src_b = 1'b0;
    aluop     = 2'b00;
    reg_write = 1'b0;
    mem2reg   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ack;
        pc_write = imem_ack;
      end
      S_EXEC: begin
        case (cls_q)
          C_R:      aluop = 2'b10;
          C_I: begin
            aluop     = 2'b10;
            alu_src_b = 1'b1;
          end
          C_BRANCH: begin
            aluop    = 2'b01;
            pc_write = zero;
            pc_src   = 1'b1;
          end
          default: begin
            aluop     = 2'b00;
            alu_src_b = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == C_STORE);
      end
      S_WB: begin
        reg_write = 1'b1;
        mem2reg   = (cls_q == C_LOAD);
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign err_code    = err_q;
  assign cycle_cnt   = cyc_q;
  assign instret_cnt = inst_q;

endmodule
